// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Instruction sequencer for the multi-cycle datapath. Steps each
//               instruction through FETCH/DECODE/EXEC/MEM/WB along an
//               opcode-dependent path, gates the control unit's raw strobes
//               to the cycle in which they are allowed to act, issues IR/PC
//               load strobes, counts retired instructions and halts on an
//               illegal opcode.
// Ports       : clk, rst              clock, synchronous active-high reset
//               hold                  stall: freezes state, counter and flag
//               opcode[5:0]           IR[31:26], valid from DECODE onward
//               cu_reg_write1/2,
//               cu_read_mem/write_mem raw strobes from control_unit
//               state[2:0]            FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7
//               ir_write, pc_write    IR / PC load strobes
//               reg_write1/2          gated register-file write enables
//               read_mem, write_mem   gated data-memory strobes
//               instret[CNT_W-1:0]    retired-instruction count (wraps)
//               illegal               sticky illegal-opcode flag
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] OPC_LAST = 6'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [5:0]       opcode,
    input  logic             cu_reg_write1,
    input  logic             cu_reg_write2,
    input  logic             cu_read_mem,
    input  logic             cu_write_mem,
    output logic [2:0]       state,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write1,
    output logic             reg_write2,
    output logic             read_mem,
    output logic             write_mem,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] c_OP_ALU_LAST  = 6'd4;
    localparam logic [5:0] c_OP_SW        = 6'd7;
    localparam logic [5:0] c_OP_BR_FIRST  = 6'd8;
    localparam logic [5:0] c_OP_BR_LAST   = 6'd11;
    localparam logic [5:0] c_OP_JMP       = 6'd12;
    localparam logic [5:0] c_OP_CALL      = 6'd13;
    localparam logic [5:0] c_OP_PUSH      = 6'd15;

    state_t           r_state;
    state_t           w_next;
    logic             w_last;       // current state is the final one of the path
    logic             w_active;     // strobes may fire this cycle
    logic             w_op_alu;
    logic             w_op_branch;
    logic             w_op_store;
    logic             w_op_illegal;
    logic             w_pc_write;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;

    // Opcode classes that decide where each path ends.
    assign w_op_alu     = (opcode <= c_OP_ALU_LAST);
    assign w_op_branch  = (opcode >= c_OP_BR_FIRST) && (opcode <= c_OP_BR_LAST);
    assign w_op_store   = (opcode == c_OP_SW) || (opcode == c_OP_CALL) ||
                          (opcode == c_OP_PUSH);
    assign w_op_illegal = (opcode > OPC_LAST);

    always_comb begin
        w_next = r_state;
        w_last = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                // Illegal opcodes never retire: no pc_write, straight to HALT.
                if (w_op_illegal) begin
                    w_next = S_HALT;
                end else if (opcode == c_OP_JMP) begin
                    w_next = S_FETCH;
                    w_last = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_op_alu) begin
                    w_next = S_WB;
                end else if (w_op_branch) begin
                    w_next = S_FETCH;
                    w_last = 1'b1;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_MEM: begin
                if (w_op_store) begin
                    w_next = S_FETCH;
                    w_last = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_next = S_FETCH;
                w_last = 1'b1;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset and stall both suppress every strobe in the current cycle so a
    // partially executed instruction can never write anything.
    assign w_active   = ~rst & ~hold;
    assign w_pc_write = w_active & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else if (!hold) begin
            r_state <= w_next;
            if (w_pc_write) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if ((r_state == S_DECODE) && (w_next == S_HALT)) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign ir_write   = w_active & (r_state == S_FETCH);
    assign pc_write   = w_pc_write;
    assign read_mem   = w_active & (r_state == S_MEM) & cu_read_mem;
    assign write_mem  = w_active & (r_state == S_MEM) & cu_write_mem;
    assign reg_write1 = w_active & (r_state == S_WB)  & cu_reg_write1;
    assign reg_write2 = w_active & (r_state == S_WB)  & cu_reg_write2;
    assign instret    = r_instret;
    assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

State-machine sequencer for the multi-cycle processor datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and gates the combinational control unit's write and memory strobes so they fire only in the correct cycle. It also issues IR/PC load strobes, counts retired instructions and halts on illegal opcodes. It sits between `control_unit` and the register file, data memory, PC and IR registers.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `OPC_LAST`, 6'd16: highest legal opcode (POP). Anything above it is illegal.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `hold`  in  1  stall request; freezes the sequencer.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `cu_reg_write1`, `cu_reg_write2`, `cu_read_mem`, `cu_write_mem`  in  1 each  raw strobes from `control_unit`.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- `ir_write`  out  1  load IR from instruction memory.
- `pc_write`  out  1  load PC from the pc_src mux (control unit selects the source).
- `reg_write1`, `reg_write2`  out  1  gated register-file write enables.
- `read_mem`, `write_mem`  out  1  gated data-memory strobes.
- `instret`  out  CNT_W  retired-instruction count.
- `illegal`  out  1  sticky flag: illegal opcode decoded.

## Operation
- Every output strobe is decoded from `state` (Moore style) and ANDed with the corresponding `cu_*` input where one exists.
- All strobes are 0 while `rst` is high, while `hold` is high, and in HALT.
- Paths by opcode, as the sequence of states visited:
  - AND/ADD/SUB/ANDI/ADDI (0–4): F→D→E→WB.
  - LW/LW_POI/POP (5,6,16): F→D→E→M→WB.
  - SW/PUSH/CALL (7,15,13): F→D→E→M.
  - RET (14): F→D→E→M→WB. Data memory output is registered, so the PC loads in WB.
  - BGT/BLT/BEQ/BNE (8–11): F→D→E.
  - JMP (12): F→D.
- FETCH: `ir_write`=1.
- EXEC: no strobes.
- MEM: `read_mem`=`cu_read_mem`, `write_mem`=`cu_write_mem`.
- WB: `reg_write1`=`cu_reg_write1`, `reg_write2`=`cu_reg_write2`.
- `pc_write`=1 only in the final state of each path (D for JMP, E for branches, M for SW/PUSH/CALL, WB otherwise).
  - The PC therefore holds the current instruction address for the whole instruction.
  - Branch-taken/not-taken is resolved by `pc_src` from live ALU flags in EXEC.
- After the final state the sequencer returns to FETCH.
- Illegal opcode (> `OPC_LAST`) seen in DECODE:
  - next state is HALT; `illegal` is set; `pc_write` is 0.
  - HALT is left only by `rst`.
- `instret` increments by 1 on every edge where `pc_write`=1 and `hold`=0. It wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset values: `state`=FETCH, `instret`=0, `illegal`=0, all strobes 0.
- The first cycle after `rst` falls is FETCH with `ir_write`=1.
- Latency per instruction: JMP 2 cycles; branches 3; ALU ops, SW, PUSH and CALL 4; LW, LW_POI, POP and RET 5.
- `hold` sampled high: state, `instret` and `illegal` unchanged on that edge; strobes 0 in that cycle. When `hold` drops, the same state re-executes with its strobes.
- `rst` mid-instruction: next state FETCH, counter cleared, and no strobe in the reset cycle, so no partial write occurs. `rst` has priority over `hold`.
- `opcode` is sampled combinationally in DECODE, EXEC, MEM and WB. The IR must not change outside FETCH.

## Test plan
- ADD (op 1) after reset → states 0,1,2,4,0. `reg_write1` high only in the WB cycle; `pc_write` high in WB; `instret` 0→1.
- LW_POI (op 6) with cu_read_mem=cu_reg_write1=cu_reg_write2=1 → states 0,1,2,3,4. `read_mem` only in MEM; both reg writes only in WB; total 5 cycles.
- BEQ (op 10) then JMP (op 12) → 3 cycles then 2 cycles; `pc_write` in EXEC, then in DECODE; `instret`=2.
- SW (op 7) with `hold` pulsed high for 2 cycles during MEM → `write_mem` 0 while held, then exactly one `write_mem` pulse after release; instruction takes 6 cycles.
- Opcode 6'd20 in DECODE → state 7 and `illegal`=1 next cycle. `pc_write` never asserts; state stays 7 for 10 cycles; `rst` returns to 0 with `illegal`=0.
- `rst` asserted in WB of a POP → no reg write that cycle, then FETCH with `instret`=0. Separately, preload `instret`=32'hFFFFFFFF (force) and retire one ADD → `instret`=0.
